// File: rtl/lc3b_types.sv
// Shared types and default widths for the LC-3b memory arbiter.
package lc3b_types;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned LINE_W_DEF = 128;
  localparam int unsigned SEL_W      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_ID_I = 1'b0,
    GNT_ID_D = 1'b1
  } gnt_id_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one physical-memory bus between the
// instruction cache (i_*) and data cache (d_*) masters.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cyc,
  input  logic              i_stb,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_adr,
  input  logic [LINE_W-1:0] i_dat_m,
  input  logic [SEL_W-1:0]  i_sel,
  output logic              i_ack,
  input  logic              d_cyc,
  input  logic              d_stb,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_adr,
  input  logic [LINE_W-1:0] d_dat_m,
  input  logic [SEL_W-1:0]  d_sel,
  output logic              d_ack,
  output logic [LINE_W-1:0] dat_s,
  output logic              m_cyc,
  output logic              m_stb,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_adr,
  output logic [LINE_W-1:0] m_dat_m,
  output logic [SEL_W-1:0]  m_sel,
  input  logic              m_ack,
  input  logic [LINE_W-1:0] m_dat_s,
  output logic [15:0]       conflicts
);

  logic       w_i_pend;
  logic       w_d_pend;
  arb_state_t r_state;
  arb_state_t w_next_state;
  gnt_id_t    r_last_gnt;
  gnt_id_t    w_next_last_gnt;
  logic [15:0] r_conflicts;
  logic [15:0] w_next_conflicts;

  assign w_i_pend  = i_cyc & i_stb;
  assign w_d_pend  = d_cyc & d_stb;
  assign dat_s     = m_dat_s;
  assign conflicts = r_conflicts;

  // Arbitration state; last_gnt resets to D so I wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last_gnt  <= GNT_ID_D;
      r_conflicts <= 16'd0;
    end else begin
      r_state     <= w_next_state;
      r_last_gnt  <= w_next_last_gnt;
      r_conflicts <= w_next_conflicts;
    end
  end

  // Next-state decision plus bus mux; acks are combinational on m_ack.
  always_comb begin
    w_next_state     = r_state;
    w_next_last_gnt  = r_last_gnt;
    w_next_conflicts = r_conflicts;
    m_cyc   = 1'b0;
    m_stb   = 1'b0;
    m_we    = 1'b0;
    m_adr   = {ADDR_W{1'b0}};
    m_dat_m = {LINE_W{1'b0}};
    m_sel   = {SEL_W{1'b0}};
    i_ack   = 1'b0;
    d_ack   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_i_pend && w_d_pend) begin
          w_next_conflicts = sat_inc16(r_conflicts);
          w_next_state     = (r_last_gnt == GNT_ID_D) ? GNT_I : GNT_D;
        end else if (w_i_pend) begin
          w_next_state = GNT_I;
        end else if (w_d_pend) begin
          w_next_state = GNT_D;
        end else begin
          w_next_state = IDLE;
        end
      end
      GNT_I: begin
        m_cyc   = 1'b1;
        m_stb   = 1'b1;
        m_we    = i_we;
        m_adr   = i_adr;
        m_dat_m = i_dat_m;
        m_sel   = i_sel;
        // A master dropping its strobe aborts without touching fairness.
        if (!w_i_pend) begin
          w_next_state = IDLE;
        end else if (m_ack) begin
          i_ack           = 1'b1;
          w_next_state    = DONE;
          w_next_last_gnt = GNT_ID_I;
        end else begin
          w_next_state = GNT_I;
        end
      end
      GNT_D: begin
        m_cyc   = 1'b1;
        m_stb   = 1'b1;
        m_we    = d_we;
        m_adr   = d_adr;
        m_dat_m = d_dat_m;
        m_sel   = d_sel;
        if (!w_d_pend) begin
          w_next_state = IDLE;
        end else if (m_ack) begin
          d_ack           = 1'b1;
          w_next_state    = DONE;
          w_next_last_gnt = GNT_ID_D;
        end else begin
          w_next_state = GNT_D;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

endmodule
